// File: rtl/ntsc_video_gen_p.sv
// rtl/ntsc_video_gen_p.sv - parametrised monochrome NTSC field generator
// Three-stage pipeline: scan counters -> pixel address/flags -> DAC code/status.
module ntsc_video_gen_p #(
  parameter int CLKS_PER_LINE   = 635,
  parameter int HSYNC_CLKS      = 47,
  parameter int BACK_PORCH_CLKS = 58,
  parameter int H_PIXELS        = 32,
  parameter int CLKS_PER_PIXEL  = 16,
  parameter int LINES_PER_FIELD = 262,
  parameter int VSYNC_LINES     = 3,
  parameter int VBLANK_LINES    = 20,
  parameter int V_PIXELS        = 16,
  parameter int LINES_PER_PIXEL = 14,
  parameter int ADDR_W          = 9,
  parameter int PIX_W           = 2,
  parameter int DAC_W           = 2,
  parameter int SYNC_LEVEL      = 0,
  parameter int BLANK_LEVEL     = 1,
  parameter int BLACK_LEVEL     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] pixelmem_address,
  output logic [DAC_W-1:0]  dacout,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              field_start
);

  localparam int H_W    = $clog2(CLKS_PER_LINE + 1);
  localparam int V_W    = $clog2(LINES_PER_FIELD + 1);
  localparam int HSUB_W = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int COL_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int VSUB_W = (LINES_PER_PIXEL > 1) ? $clog2(LINES_PER_PIXEL) : 1;
  localparam int ROW_W  = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam int SUM_W  = ((DAC_W > PIX_W) ? DAC_W : PIX_W) + 1;
  localparam int H_START = HSYNC_CLKS + BACK_PORCH_CLKS;
  localparam int H_END   = H_START + H_PIXELS * CLKS_PER_PIXEL;
  localparam int V_START = VBLANK_LINES;
  localparam int V_END   = V_START + V_PIXELS * LINES_PER_PIXEL;
  localparam int DAC_MAX = (1 << DAC_W) - 1;

  // Stage 1: scan position and dividerless column/row sub-counters
  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [HSUB_W-1:0] hsub_q, hsub_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [VSUB_W-1:0] vsub_q, vsub_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        mode_q, mode_d;

  // Stage 2: address plus region flags for the same position
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              s2_vsl_q, s2_vsl_d, s2_tip_q, s2_tip_d;
  logic              s2_hs_q, s2_hs_d, s2_act_q, s2_act_d, s2_fs_q, s2_fs_d;
  logic [PIX_W-1:0]  s2_col_q, s2_col_d;
  logic [1:0]        s2_mode_q;

  // Stage 3: registered outputs
  logic [DAC_W-1:0]  dac_q, dac_d;
  logic              hs_q, hs_d, vs_q, vs_d, act_q, act_d, fs_q, fs_d;

  logic                   h_last, v_last, h_in, v_in, in_act, at_origin;
  logic [PIX_W+COL_W-1:0] col_ext;
  logic [PIX_W-1:0]       pixel;
  logic [SUM_W-1:0]       sum;

  always_comb begin
    h_last    = (h_q == H_W'(CLKS_PER_LINE - 1));
    v_last    = (v_q == V_W'(LINES_PER_FIELD - 1));
    h_in      = (h_q >= H_W'(H_START)) && (h_q < H_W'(H_END));
    v_in      = (v_q >= V_W'(V_START)) && (v_q < V_W'(V_END));
    in_act    = h_in && v_in;
    at_origin = (h_q == '0) && (v_q == '0);

    h_d    = h_last ? '0 : h_q + H_W'(1);
    v_d    = v_q;
    hsub_d = '0;
    col_d  = '0;
    vsub_d = vsub_q;
    row_d  = row_q;
    if (h_last) v_d = v_last ? '0 : v_q + V_W'(1);

    if (h_in) begin
      if (hsub_q == HSUB_W'(CLKS_PER_PIXEL - 1)) begin
        hsub_d = '0;
        col_d  = (col_q == COL_W'(H_PIXELS - 1)) ? '0 : col_q + COL_W'(1);
      end else begin
        hsub_d = hsub_q + HSUB_W'(1);
        col_d  = col_q;
      end
    end

    // Row tracking only advances at end of line; reset whenever outside picture
    if (h_last) begin
      if (!v_in) begin
        vsub_d = '0;
        row_d  = '0;
      end else if (vsub_q == VSUB_W'(LINES_PER_PIXEL - 1)) begin
        vsub_d = '0;
        row_d  = (row_q == ROW_W'(V_PIXELS - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        vsub_d = vsub_q + VSUB_W'(1);
      end
    end

    mode_d   = at_origin ? mode : mode_q;
    addr_d   = in_act ? (ADDR_W'(row_q) * ADDR_W'(H_PIXELS) + ADDR_W'(col_q)) : addr_q;
    s2_vsl_d = (v_q < V_W'(VSYNC_LINES));
    s2_tip_d = (h_q < H_W'(CLKS_PER_LINE - HSYNC_CLKS));
    s2_hs_d  = (h_q < H_W'(HSYNC_CLKS));
    s2_act_d = in_act;
    s2_fs_d  = at_origin;
    col_ext  = {{PIX_W{1'b0}}, col_q};
    s2_col_d = col_ext[PIX_W-1:0];
  end

  always_comb begin
    case (s2_mode_q)
      2'd0:    pixel = '0;
      2'd1:    pixel = '1;
      2'd2:    pixel = s2_col_q;
      default: pixel = pix_data;
    endcase
    sum   = SUM_W'(BLACK_LEVEL) + SUM_W'(pixel);
    dac_d = DAC_W'(BLANK_LEVEL);
    hs_d  = 1'b0;
    vs_d  = 1'b0;
    act_d = 1'b0;
    fs_d  = s2_fs_q;
    if (s2_vsl_q) begin
      vs_d  = 1'b1;
      dac_d = s2_tip_q ? DAC_W'(SYNC_LEVEL) : DAC_W'(BLANK_LEVEL);
    end else if (s2_hs_q) begin
      hs_d  = 1'b1;
      dac_d = DAC_W'(SYNC_LEVEL);
    end else if (s2_act_q) begin
      act_d = 1'b1;
      dac_d = (sum > SUM_W'(DAC_MAX)) ? DAC_W'(DAC_MAX) : DAC_W'(sum);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q       <= '0;
      v_q       <= '0;
      hsub_q    <= '0;
      col_q     <= '0;
      vsub_q    <= '0;
      row_q     <= '0;
      mode_q    <= 2'd3;
      addr_q    <= '0;
      s2_vsl_q  <= 1'b0;
      s2_tip_q  <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_act_q  <= 1'b0;
      s2_fs_q   <= 1'b0;
      s2_col_q  <= '0;
      s2_mode_q <= 2'd3;
      dac_q     <= DAC_W'(BLANK_LEVEL);
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      act_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      hsub_q    <= hsub_d;
      col_q     <= col_d;
      vsub_q    <= vsub_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      s2_vsl_q  <= s2_vsl_d;
      s2_tip_q  <= s2_tip_d;
      s2_hs_q   <= s2_hs_d;
      s2_act_q  <= s2_act_d;
      s2_fs_q   <= s2_fs_d;
      s2_col_q  <= s2_col_d;
      s2_mode_q <= mode_d;
      dac_q     <= dac_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      act_q     <= act_d;
      fs_q      <= fs_d;
    end
  end

  assign pixelmem_address = addr_q;
  assign dacout           = dac_q;
  assign hsync            = hs_q;
  assign vsync            = vs_q;
  assign active           = act_q;
  assign field_start      = fs_q;

endmodule

// File: tb/tb_ntsc_video_gen_p.sv
// tb/tb_ntsc_video_gen_p.sv - scoreboard bench for ntsc_video_gen_p
// Reduced geometry keeps whole fields short; expected stream comes from a position model.
module tb_ntsc_video_gen_p;

  localparam int CPL = 40, HS = 4, BP = 4, HP = 8, CPP = 3;
  localparam int LPF = 20, VS = 2, VB = 4, VP = 4, LPP = 3;
  localparam int F = CPL * LPF;

  typedef struct packed {
    logic [1:0] dac;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic [4:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [1:0] pix_data;
  logic [4:0] addr;
  logic [1:0] dacout;
  logic       hsync, vsync, active, field_start;
  logic [1:0] mem [0:31];

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [1:0] lmode = 2'd3;
  logic [4:0] eaddr = '0;
  exp_t exp_q[$];

  int n_act = 0, n_hs = 0, n_vs = 0, n_fs = 0, n_d3 = 0, n_d0 = 0;
  int addr_max = 0;

  always #5 clk = ~clk;

  // Pixel memory: address registered by the DUT, data sampled at the next edge
  assign pix_data = mem[addr];

  ntsc_video_gen_p #(
    .CLKS_PER_LINE(CPL), .HSYNC_CLKS(HS), .BACK_PORCH_CLKS(BP),
    .H_PIXELS(HP), .CLKS_PER_PIXEL(CPP), .LINES_PER_FIELD(LPF),
    .VSYNC_LINES(VS), .VBLANK_LINES(VB), .V_PIXELS(VP), .LINES_PER_PIXEL(LPP),
    .ADDR_W(5), .PIX_W(2), .DAC_W(2),
    .SYNC_LEVEL(0), .BLANK_LEVEL(1), .BLACK_LEVEL(1)
  ) dut (
    .clk(clk), .reset(rst_n), .mode(mode), .pix_data(pix_data),
    .pixelmem_address(addr), .dacout(dacout), .hsync(hsync), .vsync(vsync),
    .active(active), .field_start(field_start)
  );

  function automatic int act_addr(input int p);
    int h, v, ha, va;
    h = p % CPL;
    v = (p / CPL) % LPF;
    ha = h - HS - BP;
    va = v - VB;
    if (ha >= 0 && ha < HP * CPP && va >= 0 && va < VP * LPP)
      return (va / LPP) * HP + ha / CPP;
    return -1;
  endfunction

  function automatic exp_t model_out(input int p, input logic [1:0] m);
    exp_t e;
    int h, v, a, pix, s;
    h = p % CPL;
    v = (p / CPL) % LPF;
    a = act_addr(p);
    e = '0;
    e.dac = 2'd1;
    e.fs = (p % F == 0);
    if (v < VS) begin
      e.vs = 1'b1;
      e.dac = (h < CPL - HS) ? 2'd0 : 2'd1;
    end else if (h < HS) begin
      e.hs = 1'b1;
      e.dac = 2'd0;
    end else if (a >= 0) begin
      case (m)
        2'd0: pix = 0;
        2'd1: pix = 3;
        2'd2: pix = (a % HP) % 4;
        default: pix = int'(mem[a]);
      endcase
      s = 1 + pix;
      if (s > 3) s = 3;
      e.act = 1'b1;
      e.dac = 2'(s);
    end
    return e;
  endfunction

  // One clock: advance the model on the edge, then apply the next inputs
  task automatic cycle(input logic r, input logic [1:0] m);
    exp_t e;
    logic er;
    logic [1:0] em;
    int a;
    @(posedge clk);
    er = rst_n;
    em = mode;
    e = '0;
    e.dac = 2'd1;
    if (er) begin
      k++;
      a = act_addr(k - 1);
      if (a >= 0) eaddr = 5'(a);
      if (k >= 2) e = model_out(k - 2, lmode);
      if ((k - 1) % F == 0) lmode = em;
    end
    #1;
    rst_n = r;
    mode = m;
    if (!er || !rst_n) begin
      k = 0;
      eaddr = '0;
      lmode = 2'd3;
      e = '0;
      e.dac = 2'd1;
    end
    e.addr = eaddr;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({dacout, hsync, vsync, active, field_start} !== {e.dac, e.hs, e.vs, e.act, e.fs}) begin
        errors++;
        $display("FAIL video t=%0t got dac=%0d hs=%0b vs=%0b act=%0b fs=%0b want dac=%0d hs=%0b vs=%0b act=%0b fs=%0b",
                 $time, dacout, hsync, vsync, active, field_start, e.dac, e.hs, e.vs, e.act, e.fs);
      end
      checks++;
      if (addr !== e.addr) begin
        errors++;
        $display("FAIL addr t=%0t got=%0d want=%0d", $time, addr, e.addr);
      end
    end
    if (rst_n) begin
      if (active) n_act++;
      if (hsync) n_hs++;
      if (vsync) n_vs++;
      if (field_start) n_fs++;
      if (dacout == 2'd3) n_d3++;
      if (dacout == 2'd0) n_d0++;
      if (int'(addr) > addr_max) addr_max = int'(addr);
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Any F consecutive outputs in a steady mode span exactly one field
  task automatic window(input logic [1:0] m, input string tag, input int want_d3);
    int a0, h0, v0, f0, d30, d00;
    a0 = n_act; h0 = n_hs; v0 = n_vs; f0 = n_fs; d30 = n_d3; d00 = n_d0;
    repeat (F) cycle(1'b1, m);
    check_int({tag, "_active"}, n_act - a0, 288);
    check_int({tag, "_hsync"}, n_hs - h0, 72);
    check_int({tag, "_vsync"}, n_vs - v0, 80);
    check_int({tag, "_field_start"}, n_fs - f0, 1);
    check_int({tag, "_dac3"}, n_d3 - d30, want_d3);
    check_int({tag, "_dac0"}, n_d0 - d00, 144);
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 2'd3;
    for (int a = 0; a < 32; a++) mem[a] = 2'((a / HP + a) % 4);

    repeat (3) cycle(1'b0, 2'd3);
    cycle(1'b1, 2'd3);
    repeat (10) cycle(1'b1, 2'd3);
    window(2'd3, "mode3", 144);

    // Mid-field switch to test bars
    repeat (F / 2) cycle(1'b1, 2'd3);
    cycle(1'b1, 2'd2);
    repeat (F) cycle(1'b1, 2'd2);
    window(2'd2, "mode2", 144);

    // Abort mid-line in the picture area, then restart
    repeat (10 * CPL + 15) cycle(1'b1, 2'd2);
    cycle(1'b0, 2'd2);
    cycle(1'b0, 2'd2);
    cycle(1'b1, 2'd2);
    repeat (5) cycle(1'b1, 2'd2);
    window(2'd2, "after_reset", 144);

    cycle(1'b1, 2'd1);
    repeat (F + 5) cycle(1'b1, 2'd1);
    window(2'd1, "mode1", 288);

    cycle(1'b1, 2'd0);
    repeat (F + 5) cycle(1'b1, 2'd0);
    window(2'd0, "mode0", 0);

    @(negedge clk);
    #1;
    check_int("addr_max", addr_max, 31);
    check_int("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntsc_video_gen_p.md
Name: ntsc_video_gen_p

Overview:
- Parametrised successor to the fixed-format monochrome NTSC video generator.
- Produces a non-interlaced 262-line composite field on a DAC_W-bit resistor-DAC output.
- Fetches pixels from a synchronous-read pixel memory with configurable resolution, pixel depth and pixel replication.
- Adds a latched mode select (blank / white / test bars / memory) and timing status outputs for downstream logic.

Parameters:
- CLKS_PER_LINE, 635: clocks per line (63.5 us at 10 MHz).
- HSYNC_CLKS, 47: clocks of horizontal sync at the start of each line.
- BACK_PORCH_CLKS, 58: blank clocks after sync, before active video.
- H_PIXELS, 32: pixels per row.
- CLKS_PER_PIXEL, 16: clocks each pixel is held.
- LINES_PER_FIELD, 262: lines per field.
- VSYNC_LINES, 3: broad-pulse lines at field start.
- VBLANK_LINES, 20: lines 0..VBLANK_LINES-1 are blank, including the vsync lines.
- V_PIXELS, 16: pixel rows.
- LINES_PER_PIXEL, 14: lines each pixel row is repeated.
- ADDR_W, 9: pixel memory address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS.
- PIX_W, 2: bits per pixel.
- DAC_W, 2: DAC output width.
- SYNC_LEVEL, 0: DAC code for sync tip.
- BLANK_LEVEL, 1: DAC code for blank.
- BLACK_LEVEL, 1: DAC code for pixel value 0.
- Legality: HSYNC_CLKS + BACK_PORCH_CLKS + H_PIXELS*CLKS_PER_PIXEL < CLKS_PER_LINE, and VBLANK_LINES + V_PIXELS*LINES_PER_PIXEL <= LINES_PER_FIELD.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- mode, in, 2: 0 = black, 1 = white, 2 = vertical test bars, 3 = pixel memory.
- pix_data, in, PIX_W: pixel memory read data, valid one clock after address.
- pixelmem_address, out, ADDR_W: pixel memory read address.
- dacout, out, DAC_W: composite video code.
- hsync, out, 1: high while dacout carries a horizontal sync pulse.
- vsync, out, 1: high during the VSYNC_LINES lines.
- active, out, 1: high while dacout carries picture content.
- field_start, out, 1: one-clock pulse on the first dacout clock of a field.

Behaviour:
- Reset is asynchronous and active-low.
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - pixelmem_address = 0.
  - dacout = BLANK_LEVEL.
  - hsync, vsync, active, field_start = 0.
  - Latched mode = 3.
- Reset asserted mid-line aborts the line immediately; scanning restarts at (0,0) after release.
- Counters:
  - h_cnt runs 0..CLKS_PER_LINE-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..LINES_PER_FIELD-1, and wraps to 0.
- Mode latch:
  - mode is sampled only when counters are at (0,0).
  - A mode change mid-field takes effect at the next field.
- Pipeline:
  - Stage 1: counters at position P.
  - Stage 2: pixelmem_address for P is registered.
  - Stage 3: dacout, hsync, vsync, active and field_start for P are registered.
  - dacout therefore lags the counters by exactly 2 clocks, and all status outputs are aligned with dacout.
  - After reset release, dacout for (0,0) appears on the 2nd rising edge.
- Regions:
  - Active region: h_act = h_cnt - HSYNC_CLKS - BACK_PORCH_CLKS with 0 <= h_act < H_PIXELS*CLKS_PER_PIXEL, and v_act = v_cnt - VBLANK_LINES with 0 <= v_act < V_PIXELS*LINES_PER_PIXEL.
  - col = h_act / CLKS_PER_PIXEL, row = v_act / LINES_PER_PIXEL; use dividerless sub-counters, not division.
- Output level selection, in priority order:
  - Vsync line (v_cnt < VSYNC_LINES): SYNC_LEVEL for h_cnt < CLKS_PER_LINE-HSYNC_CLKS, else BLANK_LEVEL. vsync = 1, hsync = 0.
  - h_cnt < HSYNC_CLKS: SYNC_LEVEL, hsync = 1.
  - Active region:
    - pixel value by latched mode: 0 → 0; 1 → all-ones; 2 → col[PIX_W-1:0]; 3 → pix_data.
    - dacout = min(BLACK_LEVEL + pixel, 2^DAC_W - 1), computed DAC_W+1 wide and saturated.
    - active = 1.
  - Otherwise BLANK_LEVEL.
- pixelmem_address:
  - Equals row*H_PIXELS + col for positions in the active region.
  - Holds its last value outside the active region.
  - Is never out of range.
  - The memory is read every active clock regardless of mode.
- field_start is high for exactly one clock, aligned with the dacout output for position (0,0).

Test Plan:
- Reset: hold reset low 3 clocks, then release → all outputs at reset values while low; field_start pulses 2 clocks after release; dacout = 0 with vsync = 1.
- Line timing, v_cnt = 30, mode 3, pix_data = 0:
  - hsync high for 47 clocks, dacout = 0.
  - Then 58 clocks at 1, then 512 clocks active = 1 with dacout = 1.
  - Then 18 clocks at 1; period is 635 clocks.
- Addressing, mode 3:
  - First active line (v = 20) steps address 0..31, each held 16 clocks.
  - Line 34 starts at 32; the last active line (243) ends at 511.
  - Lines 244..261 show no active clocks.
- Saturation, mode 3: pix_data = 0, 1, 2, 3 → dacout = 1, 2, 3, 3.
- Mode latch: switch mode 3→2 mid-field → no change until the next field_start. Then dacout cycles 1, 2, 3, 3 per 16-clock column, repeating every 4 columns.
- Reset mid-operation: assert reset at v = 100, h = 300 → outputs return to reset values asynchronously; after release, the field restarts at (0,0) and field_start appears 2 clocks later.
